// File: rtl/riscv_pkg.sv
// Shared constants for the decode/execute pipeline.
//   XLEN / CTRL_W    : datapath and control-bundle widths
//   CTRL_*           : bit positions inside the packed control bundle
//                      (multi-bit fields give their LSB position)
//   REG_ZERO         : architectural x0 index
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 12;

    // Control bundle, MSB first:
    // reg_write, mem_read, mem_write, alu_src, result_src[1:0], branch, jump, alu_ctrl[3:0]
    localparam int CTRL_REG_WRITE  = 11;
    localparam int CTRL_MEM_READ   = 10;
    localparam int CTRL_MEM_WRITE  = 9;
    localparam int CTRL_ALU_SRC    = 8;
    localparam int CTRL_RESULT_SRC = 6;   // bits [7:6]
    localparam int CTRL_BRANCH     = 5;
    localparam int CTRL_JUMP       = 4;
    localparam int CTRL_ALU_CTRL   = 0;   // bits [3:0]

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/operand_bypass.sv
// Source-operand selection for one register-file read port.
//   idx_i      : source register index (same index that drives the RF address)
//   rf_data_i  : register-file read data
//   wb_we_i    : writeback enable
//   wb_rd_i    : writeback destination index
//   wb_data_i  : writeback data
//   operand_o  : operand to capture into the EX stage
// The register file writes on the clock edge and reads combinationally, so a
// write landing on the same edge is not yet visible on rf_data_i; it is
// forwarded here. x0 is forced to zero because the RF does not guard it.
module operand_bypass
    import riscv_pkg::*;
#(
    parameter int W = riscv_pkg::XLEN
) (
    input  logic [4:0]   idx_i,
    input  logic [W-1:0] rf_data_i,
    input  logic         wb_we_i,
    input  logic [4:0]   wb_rd_i,
    input  logic [W-1:0] wb_data_i,
    output logic [W-1:0] operand_o
);

    always_comb begin
        operand_o = rf_data_i;
        if (idx_i == REG_ZERO) begin
            operand_o = '0;
        end else if (wb_we_i && (wb_rd_i == idx_i)) begin
            operand_o = wb_data_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with writeback bypass, load-use
// hazard detection, flush/hold and a saturating bubble counter.
// Inputs : clk, rst (async, active low), decode slot (if_id_valid_i, rd1_i,
//          rd2_i, rs1_i, rs2_i, rd_i, imm_i, pc_i, ctrl_i), writeback port
//          (wb_we_i, wb_rd_i, wb_data_i), flush_i, ex_hold_i
// Outputs: registered EX slot (ex_*_o), combinational stall_o,
//          bubble_cnt_o (load-use bubbles, saturating)
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN   = riscv_pkg::XLEN,
    parameter int CTRL_W = riscv_pkg::CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_id_valid_i,
    input  logic [XLEN-1:0]   rd1_i,
    input  logic [XLEN-1:0]   rd2_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [4:0]        rd_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic              wb_we_i,
    input  logic [4:0]        wb_rd_i,
    input  logic [XLEN-1:0]   wb_data_i,
    input  logic              flush_i,
    input  logic              ex_hold_i,
    output logic              ex_valid_o,
    output logic [XLEN-1:0]   ex_rd1_o,
    output logic [XLEN-1:0]   ex_rd2_o,
    output logic [4:0]        ex_rs1_o,
    output logic [4:0]        ex_rs2_o,
    output logic [4:0]        ex_rd_o,
    output logic [XLEN-1:0]   ex_imm_o,
    output logic [XLEN-1:0]   ex_pc_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   rd1_q, rd1_d, rd2_q, rd2_d;
    logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [XLEN-1:0]   imm_q, imm_d, pc_q, pc_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [1:0][4:0]      src_idx;
    logic [1:0][XLEN-1:0] src_rf;
    logic [1:0][XLEN-1:0] src_op;
    logic                 load_use;

    assign src_idx[0] = rs1_i;
    assign src_idx[1] = rs2_i;
    assign src_rf[0]  = rd1_i;
    assign src_rf[1]  = rd2_i;

    for (genvar gi = 0; gi < 2; gi++) begin : g_bypass
        operand_bypass #(.W(XLEN)) u_bypass (
            .idx_i     (src_idx[gi]),
            .rf_data_i (src_rf[gi]),
            .wb_we_i   (wb_we_i),
            .wb_rd_i   (wb_rd_i),
            .wb_data_i (wb_data_i),
            .operand_o (src_op[gi])
        );
    end

    // rs2 is compared even for formats that do not read it: a spurious
    // one-cycle stall is cheaper than decoding the format here.
    assign load_use = valid_q && ctrl_q[CTRL_MEM_READ] && (rd_q != REG_ZERO)
                   && if_id_valid_i && ((rd_q == rs1_i) || (rd_q == rs2_i));

    assign stall_o = load_use || ex_hold_i;

    always_comb begin
        valid_d = valid_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        ctrl_d  = ctrl_q;
        cnt_d   = cnt_q;
        if (ex_hold_i && !flush_i) begin
            // While frozen, keep the held operands coherent with writebacks
            // that retire underneath them.
            if (wb_we_i && (wb_rd_i != REG_ZERO) && (wb_rd_i == rs1_q)) rd1_d = wb_data_i;
            if (wb_we_i && (wb_rd_i != REG_ZERO) && (wb_rd_i == rs2_q)) rd2_d = wb_data_i;
        end else if (flush_i || load_use || !if_id_valid_i) begin
            valid_d = 1'b0;
            rd1_d   = '0;
            rd2_d   = '0;
            rs1_d   = '0;
            rs2_d   = '0;
            rd_d    = '0;
            imm_d   = '0;
            pc_d    = '0;
            ctrl_d  = '0;
            if (!flush_i && load_use && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
        end else begin
            valid_d = 1'b1;
            rd1_d   = src_op[0];
            rd2_d   = src_op[1];
            rs1_d   = rs1_i;
            rs2_d   = rs2_i;
            rd_d    = rd_i;
            imm_d   = imm_i;
            pc_d    = pc_i;
            ctrl_d  = ctrl_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            ctrl_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_valid_o   = valid_q;
    assign ex_rd1_o     = rd1_q;
    assign ex_rd2_o     = rd2_q;
    assign ex_rs1_o     = rs1_q;
    assign ex_rs2_o     = rs2_q;
    assign ex_rd_o      = rd_q;
    assign ex_imm_o     = imm_q;
    assign ex_pc_o      = pc_q;
    assign ex_ctrl_o    = ctrl_q;
    assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
`timescale 1ns/1ps
module tb_id_ex_stage;
    import riscv_pkg::*;

    localparam int CNT_W = 16;
    localparam int SAT_W = 4;   // narrow counter instance so saturation is reachable quickly
    localparam logic [CTRL_W-1:0] C_ADD = CTRL_W'(1) << CTRL_REG_WRITE;
    localparam logic [CTRL_W-1:0] C_LW  = C_ADD | (CTRL_W'(1) << CTRL_MEM_READ) | (CTRL_W'(1) << CTRL_ALU_SRC);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic              if_id_valid_i, wb_we_i, flush_i, ex_hold_i;
    logic [XLEN-1:0]   rd1_i, rd2_i, imm_i, pc_i, wb_data_i;
    logic [4:0]        rs1_i, rs2_i, rd_i, wb_rd_i;
    logic [CTRL_W-1:0] ctrl_i;

    logic              ex_valid_o, stall_o, s_valid, s_stall;
    logic [XLEN-1:0]   ex_rd1_o, ex_rd2_o, ex_imm_o, ex_pc_o, s_rd1, s_rd2, s_imm, s_pc;
    logic [4:0]        ex_rs1_o, ex_rs2_o, ex_rd_o, s_rs1, s_rs2, s_rd;
    logic [CTRL_W-1:0] ex_ctrl_o, s_ctrl;
    logic [CNT_W-1:0]  bubble_cnt_o;
    logic [SAT_W-1:0]  s_cnt;

    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .if_id_valid_i(if_id_valid_i), .rd1_i(rd1_i), .rd2_i(rd2_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .imm_i(imm_i), .pc_i(pc_i), .ctrl_i(ctrl_i),
        .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .flush_i(flush_i),
        .ex_hold_i(ex_hold_i), .ex_valid_o(ex_valid_o), .ex_rd1_o(ex_rd1_o), .ex_rd2_o(ex_rd2_o),
        .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o), .ex_imm_o(ex_imm_o),
        .ex_pc_o(ex_pc_o), .ex_ctrl_o(ex_ctrl_o), .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o)
    );

    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .rst(rst), .if_id_valid_i(if_id_valid_i), .rd1_i(rd1_i), .rd2_i(rd2_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .imm_i(imm_i), .pc_i(pc_i), .ctrl_i(ctrl_i),
        .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .flush_i(flush_i),
        .ex_hold_i(ex_hold_i), .ex_valid_o(s_valid), .ex_rd1_o(s_rd1), .ex_rd2_o(s_rd2),
        .ex_rs1_o(s_rs1), .ex_rs2_o(s_rs2), .ex_rd_o(s_rd), .ex_imm_o(s_imm),
        .ex_pc_o(s_pc), .ex_ctrl_o(s_ctrl), .stall_o(s_stall), .bubble_cnt_o(s_cnt)
    );

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   rd1, rd2;
        logic [4:0]        rs1, rs2, rd;
        logic [XLEN-1:0]   imm, pc;
        logic [CTRL_W-1:0] ctrl;
        logic [CNT_W-1:0]  cnt;
        logic [SAT_W-1:0]  cnt_s;
    } exp_t;

    exp_t m;        // reference state of the EX slot
    exp_t q[$];     // scoreboard of expected post-edge states
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [XLEN-1:0] sel_op(input logic [4:0] idx, input logic [XLEN-1:0] rf);
        if (idx == 5'd0) return '0;
        if (wb_we_i && wb_rd_i == idx) return wb_data_i;
        return rf;
    endfunction

    task automatic set_dec(input logic v, input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                           input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2, input logic [CTRL_W-1:0] c);
        if_id_valid_i = v; rs1_i = s1; rs2_i = s2; rd_i = d;
        rd1_i = r1; rd2_i = r2; ctrl_i = c; imm_i = $urandom; pc_i = $urandom;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] d, input logic [XLEN-1:0] data);
        wb_we_i = we; wb_rd_i = d; wb_data_i = data;
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {ex_valid_o, ex_rd1_o, ex_rd2_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_imm_o, ex_pc_o,
                  ex_ctrl_o, bubble_cnt_o}, '0);
        chk({tag, "_sat"}, {s_valid, s_rd1, s_rd2, s_rs1, s_rs2, s_rd, s_imm, s_pc, s_ctrl, s_cnt}, '0);
    endtask

    // One clock: check stall, predict next state, push, clock, pop and compare.
    task automatic cycle();
        exp_t n, e;
        logic lu;
        #1;
        lu = m.valid && m.ctrl[CTRL_MEM_READ] && (m.rd != 5'd0) && if_id_valid_i
             && ((m.rd == rs1_i) || (m.rd == rs2_i));
        chk("stall", stall_o, lu || ex_hold_i);
        n = '0;
        n.cnt = m.cnt;
        n.cnt_s = m.cnt_s;
        if (flush_i) begin
            // bubble, counter untouched
        end else if (ex_hold_i) begin
            n = m;
            if (wb_we_i && wb_rd_i != 5'd0 && wb_rd_i == m.rs1) n.rd1 = wb_data_i;
            if (wb_we_i && wb_rd_i != 5'd0 && wb_rd_i == m.rs2) n.rd2 = wb_data_i;
        end else if (lu) begin
            if (m.cnt != {CNT_W{1'b1}}) n.cnt = m.cnt + 1'b1;
            if (m.cnt_s != {SAT_W{1'b1}}) n.cnt_s = m.cnt_s + 1'b1;
        end else if (if_id_valid_i) begin
            n.valid = 1'b1;
            n.rd1 = sel_op(rs1_i, rd1_i);
            n.rd2 = sel_op(rs2_i, rd2_i);
            n.rs1 = rs1_i; n.rs2 = rs2_i; n.rd = rd_i;
            n.imm = imm_i; n.pc = pc_i; n.ctrl = ctrl_i;
        end
        m = n;
        q.push_back(n);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("valid", ex_valid_o, e.valid);
        chk("rd1", ex_rd1_o, e.rd1);
        chk("rd2", ex_rd2_o, e.rd2);
        chk("idx", {ex_rs1_o, ex_rs2_o, ex_rd_o}, {e.rs1, e.rs2, e.rd});
        chk("imm_pc", {ex_imm_o, ex_pc_o}, {e.imm, e.pc});
        chk("ctrl", ex_ctrl_o, e.ctrl);
        chk("bubble_cnt", bubble_cnt_o, e.cnt);
        chk("sat_fields", {s_valid, s_rd1, s_rd2, s_rs1, s_rs2, s_rd, s_imm, s_pc, s_ctrl, s_stall},
                          {e.valid, e.rd1, e.rd2, e.rs1, e.rs2, e.rd, e.imm, e.pc, e.ctrl, stall_o});
        chk("sat_cnt", s_cnt, e.cnt_s);
    endtask

    initial begin
        m = '0;
        flush_i = 0; ex_hold_i = 0;
        set_wb(0, 0, 0);
        set_dec(0, 0, 0, 0, 0, 0, 0);

        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            set_dec(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, CTRL_W'($urandom));
            set_wb(1'($urandom), 5'($urandom), $urandom);
            flush_i = 1'($urandom); ex_hold_i = 1'($urandom);
            @(posedge clk); #1;
            chk_zero("reset_hold");
            chk("reset_stall", stall_o, ex_hold_i);
        end
        flush_i = 0; ex_hold_i = 0;
        #2 rst = 1;

        // Same-cycle writeback bypass, then plain RF data
        set_dec(1, 5, 6, 3, 32'h11, 32'h22, C_ADD);
        set_wb(1, 5, 32'hDEADBEEF);
        cycle();
        chk("bypass_rd1", ex_rd1_o, 32'hDEADBEEF);
        chk("bypass_rd2", ex_rd2_o, 32'h22);
        set_wb(0, 5, 32'hDEADBEEF);
        cycle();
        chk("nobypass_rd1", ex_rd1_o, 32'h11);

        // x0 forced to zero even with a writeback to index 0
        set_dec(1, 1, 0, 3, 32'h33, 32'h1234, C_ADD);
        set_wb(1, 0, 32'h5555);
        cycle();
        chk("x0_rd2", ex_rd2_o, 32'h0);
        chk("x0_rd1", ex_rd1_o, 32'h33);

        // Load-use on rs1
        set_wb(0, 0, 0);
        set_dec(1, 2, 3, 7, 32'h1, 32'h2, C_LW);
        cycle();
        set_dec(1, 7, 8, 9, 32'h70, 32'h80, C_ADD);
        #1 chk("lu_stall", stall_o, 1'b1);
        cycle();
        chk("lu_bubble", {ex_valid_o, ex_ctrl_o, bubble_cnt_o}, {1'b0, {CTRL_W{1'b0}}, 16'd1});
        #1 chk("lu_release", stall_o, 1'b0);
        cycle();
        chk("lu_load", {ex_valid_o, ex_rd_o}, {1'b1, 5'd9});

        // Load-use on rs2 (compared unconditionally)
        set_dec(1, 2, 3, 7, 32'h1, 32'h2, C_LW);
        cycle();
        set_dec(1, 1, 7, 12, 32'h10, 32'h20, C_ADD);
        #1 chk("lu2_stall", stall_o, 1'b1);
        cycle();
        chk("lu2_cnt", bubble_cnt_o, 16'd2);
        cycle();

        // Asynchronous reset mid-cycle with a valid EX slot
        chk("pre_reset_valid", ex_valid_o, 1'b1);
        rst = 0;
        #1 chk_zero("mid_reset");
        rst = 1;
        m = '0;

        // Flush + hold + load-use together: flush wins, counter unchanged
        set_dec(1, 2, 3, 7, 32'h1, 32'h2, C_LW);
        cycle();
        set_dec(1, 7, 0, 9, 32'h70, 32'h80, C_ADD);
        flush_i = 1; ex_hold_i = 1;
        cycle();
        chk("flush_bubble", {ex_valid_o, ex_ctrl_o, bubble_cnt_o}, '0);

        // Hold for three cycles with writeback refresh
        flush_i = 0; ex_hold_i = 0;
        set_dec(1, 4, 6, 10, 32'hAAAA, 32'hBBBB, C_ADD);
        cycle();
        ex_hold_i = 1;
        set_dec(1, 20, 21, 22, 32'h9999, 32'h8888, C_LW);
        cycle();
        chk("hold_frozen", {ex_rd1_o, ex_rd_o}, {32'hAAAA, 5'd10});
        set_wb(1, 4, 32'hCAFE);
        cycle();
        chk("hold_refresh1", ex_rd1_o, 32'hCAFE);
        set_wb(1, 6, 32'hF00D);
        cycle();
        chk("hold_refresh2", {ex_rd1_o, ex_rd2_o, ex_rd_o}, {32'hCAFE, 32'hF00D, 5'd10});
        ex_hold_i = 0;
        set_wb(0, 0, 0);

        // Empty decode slot
        set_dec(0, 1, 2, 3, 32'h5, 32'h6, C_ADD);
        cycle();
        chk("invalid_bubble", ex_valid_o, 1'b0);

        // Random traffic over a narrow index range to hit hazards and bypasses
        for (int i = 0; i < 300; i++) begin
            set_dec($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), $urandom, $urandom, CTRL_W'($urandom));
            set_wb(1'($urandom), 5'($urandom_range(0, 7)), $urandom);
            flush_i = ($urandom_range(0, 9) == 0);
            ex_hold_i = ($urandom_range(0, 7) == 0);
            cycle();
        end

        // Self-dependent loads: one bubble every other cycle until saturation
        flush_i = 0; ex_hold_i = 0;
        set_wb(0, 0, 0);
        set_dec(1, 7, 7, 7, 32'h1, 32'h2, C_LW);
        for (int i = 0; i < 40; i++) cycle();
        chk("sat_value", s_cnt, 4'hF);
        cycle();
        cycle();
        chk("sat_stays", s_cnt, 4'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register. Sits directly downstream of the register file.
- Captures the register-file read data (RD1/RD2) and decoded fields each cycle.
- Applies same-cycle writeback bypass, because the register file writes on posedge and reads combinationally.
- Detects load-use hazards, inserts bubbles, supports flush/hold, and counts inserted bubbles.

Parameters:
- XLEN, 32, datapath width
- CTRL_W, 12, packed control bundle width (reg_write, mem_read, mem_write, alu_src, result_src[1:0], branch, jump, alu_ctrl[3:0])
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- if_id_valid_i  in  1  decode slot holds a real instruction
- rd1_i  in  XLEN  register file RD1
- rd2_i  in  XLEN  register file RD2
- rs1_i  in  5  source register 1 index (drives A1)
- rs2_i  in  5  source register 2 index (drives A2)
- rd_i  in  5  destination index
- imm_i  in  XLEN  extended immediate
- pc_i  in  XLEN  instruction PC
- ctrl_i  in  CTRL_W  decoded control bundle
- wb_we_i  in  1  writeback enable (same signal as register file WE3)
- wb_rd_i  in  5  writeback index (A3)
- wb_data_i  in  XLEN  writeback data (WD3)
- flush_i  in  1  taken branch/jump from EX; kill decode slot
- ex_hold_i  in  1  EX cannot accept; freeze this stage
- ex_valid_o  out  1  EX slot valid
- ex_rd1_o  out  XLEN  operand 1 to EX
- ex_rd2_o  out  XLEN  operand 2 to EX
- ex_rs1_o  out  5  registered rs1
- ex_rs2_o  out  5  registered rs2
- ex_rd_o  out  5  registered rd
- ex_imm_o  out  XLEN  registered immediate
- ex_pc_o  out  XLEN  registered PC
- ex_ctrl_o  out  CTRL_W  registered control; all zero when invalid
- stall_o  out  1  combinational; upstream (PC, IF/ID) must hold
- bubble_cnt_o  out  CNT_W  saturating count of load-use bubbles

Behaviour:
- Reset (rst=0, asynchronous): all registered outputs 0, including ex_valid_o, ex_ctrl_o and bubble_cnt_o. Takes effect immediately, mid-cycle included. On release, the first edge loads normally.
- load_use = ex_valid_o & ex_ctrl_o.mem_read & (ex_rd_o!=0) & if_id_valid_i & (ex_rd_o==rs1_i | ex_rd_o==rs2_i). rs2 is compared unconditionally (conservative).
- stall_o = load_use | ex_hold_i. It is combinational, with no register delay.
- Per posedge, first matching case wins:
  1. flush_i: bubble. ex_valid_o<=0, ex_ctrl_o<=0, all other fields <=0. Flush beats hold.
  2. ex_hold_i: retain all fields. Refresh only: if wb_we_i & wb_rd_i!=0 & wb_rd_i==ex_rs1_o, then ex_rd1_o<=wb_data_i (same for rs2/rd2).
  3. load_use: bubble as in case 1. bubble_cnt_o increments, saturating at all-ones.
  4. !if_id_valid_i: bubble.
  5. Otherwise load all fields and set ex_valid_o<=1.
- Operand selection on load, rs1 path (rs2 identical):
  - If rs1_i==0, capture 0. x0 is forced to 0 here because the register file does not guard index 0.
  - Else if wb_we_i & wb_rd_i==rs1_i, capture wb_data_i (bypass).
  - Else capture rd1_i.
- Latency: 1 cycle from decode to EX outputs.
- A load-use stall lasts exactly 1 cycle: after the bubble, ex_valid_o=0, so load_use deasserts.
- flush_i together with load_use: flush wins and the counter does not increment.
- The counter does not wrap.

Decomposition:
- Shared package (riscv_pkg):
  - XLEN and CTRL_W constants
  - control-bundle bit-position constants: CTRL_REG_WRITE, CTRL_MEM_READ, CTRL_MEM_WRITE, CTRL_ALU_SRC, CTRL_RESULT_SRC (2b), CTRL_BRANCH, CTRL_JUMP, CTRL_ALU_CTRL (4b)
  - REG_ZERO=5'd0
- One sub-module is natural: operand_bypass, instantiated twice. Inputs: index, regfile data, wb_we/rd/data. Output: selected operand, including the x0 rule.

Test Plan:
- Reset: hold rst=0 with random inputs -> every output 0. Assert rst=0 mid-run with ex_valid_o=1 -> outputs clear before the next edge.
- Bypass: rs1_i=5, rd1_i=0x11, wb_we_i=1, wb_rd_i=5, wb_data_i=0xDEADBEEF -> ex_rd1_o=0xDEADBEEF next cycle. Same with wb_we_i=0 -> 0x11.
- x0: rs2_i=0, rd2_i=0x1234, wb_we_i=1, wb_rd_i=0 -> ex_rd2_o=0.
- Load-use: EX holds lw with rd=7 (mem_read=1). Decode presents rs1_i=7 -> stall_o=1 same cycle; next edge ex_valid_o=0, ex_ctrl_o=0, bubble_cnt_o=1. The following cycle stall_o=0 and the instruction loads.
- Flush vs hold: flush_i=1, ex_hold_i=1 -> bubble, counter unchanged. Then ex_hold_i=1 alone for 3 cycles -> fields frozen; a WB to ex_rs1_o during the hold updates ex_rd1_o.
- Saturation: force 2^16+2 load-use events -> bubble_cnt_o=0xFFFF and stays there.
